tlp_replay_writer: RTL and testbench
====================================

Name: tlp_replay_writer

Overview:
- Sits directly upstream of the retry manager in the DLL transmit path.
- Accepts outbound TLPs from the transaction layer on AXIS and assigns each one a 12-bit sequence number.
- Stores the TLP into the replay BRAM slot chosen by the retry manager, forwards it downstream with a sequence-number prefix DW, and pulses tx_valid_o/tx_seq_num_o at commit so the retry manager arms its replay timer.

Parameters:
- DATA_WIDTH, 32, AXIS data width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width; passed through unchanged.
- MAX_PAYLOAD_SIZE, 0, PCIe MPS encoding; sets slot size.
- RAM_DATA_WIDTH, 32, replay BRAM word width.
- RAM_ADDR_WIDTH, 10, replay BRAM address width.
- SLOT_WORDS, 5 + (8 << (4+MAX_PAYLOAD_SIZE)), BRAM words per replay slot (133 at MPS=0).

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset.
- s_axis_tdata/tkeep/tvalid/tlast/tuser in DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH: TLP input.
- s_axis_tready out 1: TLP input ready.
- m_axis_tdata/tkeep/tvalid/tlast/tuser out (same widths): framed TLP output.
- m_axis_tready in 1: downstream ready.
- retry_available_i in 1: a replay slot is free.
- retry_index_i in 8: slot to use.
- tx_valid_o out 1: one-cycle commit pulse.
- tx_seq_num_o out 12: sequence number of the committed TLP.
- bram_wr_o out 1: BRAM write strobe.
- bram_addr_o out RAM_ADDR_WIDTH: BRAM address.
- bram_data_out_o out RAM_DATA_WIDTH: BRAM write data.
- overflow_o out 1: sticky, TLP exceeded slot capacity.

Behaviour:
- One clock, clk_i; reset is asynchronous and active-low (rst_ni).
- Reset values:
  - all m_axis outputs 0, s_axis_tready 0, tx_valid_o 0, tx_seq_num_o 0;
  - bram_wr_o 0, bram_addr_o 0, bram_data_out_o 0, overflow_o 0;
  - internal next_seq 0, state ST_IDLE.
- Reset mid-TLP abandons the TLP: no commit pulse, no seq increment; a partial slot write is harmless.
- Output register: single stage. A beat is accepted when m_axis_tvalid=0 or m_axis_tready=1. Registered m_axis data is held stable while stalled.
- FSM:
  - ST_IDLE:
    - s_axis_tready=0.
    - If s_axis_tvalid && retry_available_i, latch slot=retry_index_i and seq=next_seq, clear count, then go to ST_PREFIX.
    - retry_index_i is sampled only here.
  - ST_PREFIX:
    - When the output register can accept, load m_axis_tdata={20'h0,seq}, tkeep='1, tlast=0, tuser=0, then go to ST_STREAM.
    - The prefix is not stored in BRAM.
  - ST_STREAM:
    - s_axis_tready = output register can accept.
    - Each accepted beat is copied to the output register (tdata/tkeep/tlast/tuser).
    - If count < SLOT_WORDS-1: bram_wr_o=1, addr=slot*SLOT_WORDS+1+count, data=tdata, count+1.
    - Else the beat is not stored and overflow_o is set (sticky until reset); forwarding continues.
    - An accepted beat with tlast goes to ST_COMMIT.
  - ST_COMMIT (exactly one cycle):
    - bram_wr_o=1, addr=slot*SLOT_WORDS, data={16'h0, count[15:0]}.
    - tx_valid_o=1, tx_seq_num_o=seq, next_seq=(seq+1) mod 4096.
    - Then go to ST_IDLE.
- Address arithmetic is computed at full width, then truncated to RAM_ADDR_WIDTH.
- Sequence wraps 4095 -> 0.
- A commit pulse is never back-to-back with the next commit: minimum 3 cycles between commits. This gives the retry manager time to update retry_index_i.
- If retry_available_i drops while in ST_IDLE, input stalls indefinitely; no timeout.
- A 1-beat TLP (tlast on first beat) gives count=1.

Optional Feature:
- Macro TLP_REPLAY_WR_STATS_EN.
- Defined:
  - adds output tlp_count_o [31:0], reset 0, increments by 1 in each ST_COMMIT cycle, wraps at 2^32;
  - adds output drop_beats_o [15:0], counting beats not stored due to overflow, saturating at 16'hFFFF.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset, then a 4-beat TLP (0x11..0x44), retry_index_i=2, m_axis_tready=1 ->
  - m_axis emits 0x000,0x11,0x22,0x33,0x44 with tlast on 0x44;
  - BRAM writes 267..270 with data, then 266=4;
  - one tx_valid_o pulse with tx_seq_num_o=0.
- Three back-to-back TLPs -> tx_seq_num_o 0,1,2; commit pulses at least 3 cycles apart; each slot uses the retry_index_i sampled at its ST_IDLE.
- Force next_seq=4095 (send 4095 TLPs), then send 2 more -> prefixes 0xFFF then 0x000.
- retry_available_i=0 with s_axis_tvalid=1 -> s_axis_tready stays 0 and no BRAM writes; raise it -> TLP proceeds.
- Random m_axis_tready backpressure (50%) on a 10-beat TLP -> output data order and stability preserved, no beat lost or duplicated, commit count=10.
- 140-beat TLP at MPS=0 -> 132 data writes, overflow_o=1, all 140 beats forwarded, count word=132; assert rst_ni mid-TLP -> all outputs 0, next TLP uses seq 0.

Source files
------------

// File: rtl/tlp_replay_writer.sv
// Transmit-side replay writer: numbers each outbound TLP, stores it in its replay slot and forwards it with a sequence prefix.
// Optional statistics outputs are enabled with `define TLP_REPLAY_WR_STATS_EN.
module tlp_replay_writer #(
    parameter int DATA_WIDTH       = 32,
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int USER_WIDTH       = 1,
    parameter int MAX_PAYLOAD_SIZE = 0,
    parameter int RAM_DATA_WIDTH   = 32,
    parameter int RAM_ADDR_WIDTH   = 10,
    parameter int SLOT_WORDS       = 5 + (8 << (4 + MAX_PAYLOAD_SIZE))
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    input  logic                      m_axis_tready,
    input  logic                      retry_available_i,
    input  logic [7:0]                retry_index_i,
    output logic                      tx_valid_o,
    output logic [11:0]               tx_seq_num_o,
    output logic                      bram_wr_o,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] bram_data_out_o,
`ifdef TLP_REPLAY_WR_STATS_EN
    output logic [31:0]               tlp_count_o,
    output logic [15:0]               drop_beats_o,
`endif
    output logic                      overflow_o
);

    // state     | meaning
    // ST_IDLE   | waiting for a TLP and a free replay slot
    // ST_PREFIX | loading the sequence-number prefix DW into the output register
    // ST_STREAM | forwarding payload beats and writing them into the slot
    // ST_COMMIT | writing the slot length word and pulsing the commit
    typedef enum logic [1:0] {ST_IDLE, ST_PREFIX, ST_STREAM, ST_COMMIT} state_t;

    state_t                    state, state_n;
    logic [7:0]                slot, slot_n;
    logic [11:0]               seq, seq_n, next_seq, next_seq_n;
    logic [15:0]               count, count_n;
    logic [DATA_WIDTH-1:0]     tdata_n;
    logic [KEEP_WIDTH-1:0]     tkeep_n;
    logic                      tvalid_n, tlast_n;
    logic [USER_WIDTH-1:0]     tuser_n;
    logic                      tx_valid_n;
    logic [11:0]               tx_seq_n;
    logic                      bram_wr_n;
    logic [RAM_ADDR_WIDTH-1:0] bram_addr_n;
    logic [RAM_DATA_WIDTH-1:0] bram_data_n;
    logic                      overflow_n;
    logic                      can_accept, beat_ok, store;
    logic [31:0]               slot_base;
`ifdef TLP_REPLAY_WR_STATS_EN
    logic [31:0]               tlp_count_n;
    logic [15:0]               drop_beats_n;
`endif

    assign can_accept    = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_STREAM) && can_accept;
    assign beat_ok       = s_axis_tready && s_axis_tvalid;
    assign store         = count < 16'(SLOT_WORDS - 1);
    assign slot_base     = 32'(slot) * 32'(SLOT_WORDS);

    always_comb begin
        state_n     = state;
        slot_n      = slot;
        seq_n       = seq;
        next_seq_n  = next_seq;
        count_n     = count;
        tdata_n     = m_axis_tdata;
        tkeep_n     = m_axis_tkeep;
        tvalid_n    = m_axis_tvalid && !m_axis_tready;
        tlast_n     = m_axis_tlast;
        tuser_n     = m_axis_tuser;
        tx_valid_n  = 1'b0;
        tx_seq_n    = tx_seq_num_o;
        bram_wr_n   = 1'b0;
        bram_addr_n = bram_addr_o;
        bram_data_n = bram_data_out_o;
        overflow_n  = overflow_o;
`ifdef TLP_REPLAY_WR_STATS_EN
        tlp_count_n  = tlp_count_o;
        drop_beats_n = drop_beats_o;
`endif
        unique case (state)
            ST_IDLE: begin
                // Hold off while the previous commit pulse is visible so the
                // retry manager has a cycle to present the next slot index.
                if (s_axis_tvalid && retry_available_i && !tx_valid_o) begin
                    slot_n  = retry_index_i;
                    seq_n   = next_seq;
                    count_n = '0;
                    state_n = ST_PREFIX;
                end
            end
            ST_PREFIX: begin
                if (can_accept) begin
                    tdata_n  = DATA_WIDTH'(seq);
                    tkeep_n  = '1;
                    tvalid_n = 1'b1;
                    tlast_n  = 1'b0;
                    tuser_n  = '0;
                    state_n  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat_ok) begin
                    tdata_n  = s_axis_tdata;
                    tkeep_n  = s_axis_tkeep;
                    tvalid_n = 1'b1;
                    tlast_n  = s_axis_tlast;
                    tuser_n  = s_axis_tuser;
                    if (store) begin
                        bram_wr_n   = 1'b1;
                        bram_addr_n = RAM_ADDR_WIDTH'(slot_base + 32'd1 + 32'(count));
                        bram_data_n = RAM_DATA_WIDTH'(s_axis_tdata);
                        count_n     = count + 16'd1;
                    end else begin
                        overflow_n = 1'b1;
`ifdef TLP_REPLAY_WR_STATS_EN
                        if (drop_beats_o != 16'hFFFF)
                            drop_beats_n = drop_beats_o + 16'd1;
`endif
                    end
                    if (s_axis_tlast)
                        state_n = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                bram_wr_n   = 1'b1;
                bram_addr_n = RAM_ADDR_WIDTH'(slot_base);
                bram_data_n = RAM_DATA_WIDTH'(count);
                tx_valid_n  = 1'b1;
                tx_seq_n    = seq;
                next_seq_n  = seq + 12'd1;
`ifdef TLP_REPLAY_WR_STATS_EN
                tlp_count_n = tlp_count_o + 32'd1;
`endif
                state_n     = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= ST_IDLE;
            slot            <= '0;
            seq             <= '0;
            next_seq        <= '0;
            count           <= '0;
            m_axis_tdata    <= '0;
            m_axis_tkeep    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= '0;
            tx_valid_o      <= 1'b0;
            tx_seq_num_o    <= '0;
            bram_wr_o       <= 1'b0;
            bram_addr_o     <= '0;
            bram_data_out_o <= '0;
            overflow_o      <= 1'b0;
`ifdef TLP_REPLAY_WR_STATS_EN
            tlp_count_o     <= '0;
            drop_beats_o    <= '0;
`endif
        end else begin
            state           <= state_n;
            slot            <= slot_n;
            seq             <= seq_n;
            next_seq        <= next_seq_n;
            count           <= count_n;
            m_axis_tdata    <= tdata_n;
            m_axis_tkeep    <= tkeep_n;
            m_axis_tvalid   <= tvalid_n;
            m_axis_tlast    <= tlast_n;
            m_axis_tuser    <= tuser_n;
            tx_valid_o      <= tx_valid_n;
            tx_seq_num_o    <= tx_seq_n;
            bram_wr_o       <= bram_wr_n;
            bram_addr_o     <= bram_addr_n;
            bram_data_out_o <= bram_data_n;
            overflow_o      <= overflow_n;
`ifdef TLP_REPLAY_WR_STATS_EN
            tlp_count_o     <= tlp_count_n;
            drop_beats_o    <= drop_beats_n;
`endif
        end
    end

endmodule

// File: tb/tb_tlp_replay_writer.sv
// Scoreboard bench for tlp_replay_writer: expected beats, slot writes and commits are queued as TLPs are driven.
module tb_tlp_replay_writer;

    localparam int SLOT = 133;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tuser = '0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        retry_available_i = 1'b0;
    logic [7:0]  retry_index_i = '0;
    logic        tx_valid_o;
    logic [11:0] tx_seq_num_o;
    logic        bram_wr_o;
    logic [9:0]  bram_addr_o;
    logic [31:0] bram_data_out_o;
    logic        overflow_o;

    tlp_replay_writer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .retry_available_i(retry_available_i), .retry_index_i(retry_index_i),
        .tx_valid_o(tx_valid_o), .tx_seq_num_o(tx_seq_num_o),
        .bram_wr_o(bram_wr_o), .bram_addr_o(bram_addr_o), .bram_data_out_o(bram_data_out_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          nbeats;
        logic [7:0]  slot;
        logic [31:0] base;
        bit          rand_rdy;
        bit          exp_ovf;
    } vec_t;

    beat_t       exp_beats[$];
    wr_t         exp_wr[$];
    logic [11:0] exp_commit[$];

    int  checks = 0;
    int  failures = 0;
    int  exp_seq = 0;
    int  cyc = 0;
    int  last_commit_cyc = -100;
    int  wr_seen = 0;
    bit  rand_rdy = 1'b0;
    bit  ignore = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // ready driver
    initial forever begin
        @(posedge clk_i);
        #1;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor
    initial begin
        beat_t       eb;
        wr_t         ew;
        logic [11:0] es;
        bit          stall_prev;
        logic [37:0] stall_beat;
        stall_prev = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni || ignore) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("m_axis_stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                          {1'b1, stall_beat});
                stall_prev = m_axis_tvalid && !m_axis_tready;
                stall_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_beats.size() == 0) check("m_axis_extra_beat", 1, 0);
                    else begin
                        eb = exp_beats.pop_front();
                        check("m_axis_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, eb);
                    end
                end
                if (bram_wr_o) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) check("bram_extra_write", 1, 0);
                    else begin
                        ew = exp_wr.pop_front();
                        check("bram_write", {bram_addr_o, bram_data_out_o}, ew);
                    end
                end
                if (tx_valid_o) begin
                    check("commit_spacing_ok", (cyc - last_commit_cyc) >= 4, 1);
                    last_commit_cyc = cyc;
                    if (exp_commit.size() == 0) check("commit_extra", 1, 0);
                    else begin
                        es = exp_commit.pop_front();
                        check("tx_seq_num", tx_seq_num_o, es);
                    end
                end
            end
        end
    end

    task automatic send_tlp(input int n, input logic [7:0] slot, input logic [31:0] base, input bit rr);
        int          k;
        int          budget;
        int          stored;
        bit          hs;
        logic [31:0] d;
        rand_rdy = rr;
        exp_beats.push_back({20'h0, exp_seq[11:0], 4'hF, 1'b0, 1'b0});
        stored = (n < SLOT - 1) ? n : SLOT - 1;
        for (int i = 0; i < n; i++) begin
            d = base * (i + 1);
            exp_beats.push_back({d, 4'hF, (i == n - 1), i[0]});
            if (i < SLOT - 1) exp_wr.push_back({10'(slot * SLOT + 1 + i), d});
        end
        exp_wr.push_back({10'(slot * SLOT), 32'(stored)});
        exp_commit.push_back(exp_seq[11:0]);
        exp_seq = (exp_seq + 1) % 4096;
        retry_index_i = slot;
        retry_available_i = 1'b1;
        k = 0;
        budget = 0;
        while (k < n && budget < 2000) begin
            s_axis_tdata  = base * (k + 1);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (k == n - 1);
            s_axis_tuser  = 1'(k & 1);
            s_axis_tvalid = 1'b1;
            @(negedge clk_i);
            hs = s_axis_tready;
            @(posedge clk_i);
            #1;
            if (hs) k++;
            budget++;
        end
        if (k < n) check("send_timeout", 1, 0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_beats.size() + exp_wr.size() + exp_commit.size()) != 0 && b < 3000) begin
            @(posedge clk_i);
            b++;
        end
        check("drain_empty", exp_beats.size() + exp_wr.size() + exp_commit.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rand_rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
        check({tag, "_s_tready"}, s_axis_tready, 0);
        check({tag, "_tx"}, {tx_valid_o, tx_seq_num_o}, 0);
        check({tag, "_bram"}, {bram_wr_o, bram_addr_o, bram_data_out_o}, 0);
        check({tag, "_overflow"}, overflow_o, 0);
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   w0;
        vecs[0] = '{4,   8'd2, 32'h11,  1'b0, 1'b0};
        vecs[1] = '{1,   8'd0, 32'h101, 1'b0, 1'b0};
        vecs[2] = '{2,   8'd1, 32'h202, 1'b0, 1'b0};
        vecs[3] = '{3,   8'd3, 32'h303, 1'b0, 1'b0};
        vecs[4] = '{10,  8'd4, 32'hA5,  1'b1, 1'b0};
        vecs[5] = '{140, 8'd5, 32'h7,   1'b0, 1'b1};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int v = 0; v < 6; v++) begin
            send_tlp(vecs[v].nbeats, vecs[v].slot, vecs[v].base, vecs[v].rand_rdy);
            // entries 1..3 go back to back; drain only between groups
            if (v == 0 || v >= 3) begin
                drain();
                check("overflow_flag", overflow_o, vecs[v].exp_ovf);
            end
        end

        // reset in the middle of a TLP
        ignore = 1'b1;
        retry_index_i = 8'd1;
        retry_available_i = 1'b1;
        s_axis_tdata = 32'hAA;
        s_axis_tkeep = 4'hF;
        s_axis_tvalid = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ignore = 1'b0;
        exp_seq = 0;
        send_tlp(2, 8'd1, 32'h55, 1'b0);
        drain();

        // stall while no replay slot is available
        retry_available_i = 1'b0;
        s_axis_tdata = 32'h99;
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b1;
        w0 = wr_seen;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("no_slot_tready", s_axis_tready, 0);
        end
        check("no_slot_writes", wr_seen - w0, 0);
        @(posedge clk_i);
        #1;
        send_tlp(1, 8'd6, 32'h99, 1'b0);
        drain();

        // sequence wrap
        while (exp_seq != 4095) send_tlp(1, 8'd0, 32'h1234, 1'b0);
        drain();
        check("seq_before_wrap", exp_seq, 4095);
        send_tlp(1, 8'd0, 32'hBEEF, 1'b0);
        send_tlp(1, 8'd1, 32'hCAFE, 1'b0);
        drain();
        check("last_commit_seq", tx_seq_num_o, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
